// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// data load/store, holding each completed result until the pipeline advances.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                iready_n,
   input  logic [1:0]          d_rw,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                dready_n,
   output logic                dbusy,
   input  logic                pipe_adv,
   output logic                m_req,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_be,
   input  logic                m_ack,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                bus_err
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

   state_t            state_reg, state_next;
   logic              i_valid_reg, d_valid_reg, w_done_reg;
   logic [DATA_W-1:0] i_rdata_reg, d_rdata_reg;
   logic [ADDR_W-1:0] m_addr_reg;
   logic [DATA_W-1:0] m_wdata_reg;
   logic [BE_W-1:0]   m_be_reg;
   logic              m_we_reg;
   logic [7:0]        cnt_reg, cnt_next;
   logic              bus_err_reg;
   logic              set_i, set_d, set_w, start;

   always_comb begin
      state_next = state_reg;
      set_i      = 1'b0;
      set_d      = 1'b0;
      set_w      = 1'b0;
      cnt_next   = 8'd0;
      case (state_reg)
         IDLE: begin
            // d_rw=11 falls into the read branch first
            if (d_rw[1] && !d_valid_reg)
               state_next = DREAD;
            else if (d_rw[0] && !w_done_reg)
               state_next = DWRITE;
            else if (i_req && !i_valid_reg)
               state_next = IFETCH;
         end
         default: begin
            if (m_ack) begin
               state_next = IDLE;
               // a redirected fetch drops its data and is simply refetched
               set_i = (state_reg == IFETCH) && (m_addr_reg == i_addr);
               set_d = (state_reg == DREAD);
               set_w = (state_reg == DWRITE);
            end else begin
               cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
            end
         end
      endcase
      start = (state_reg == IDLE) && (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         i_valid_reg <= 1'b0;
         d_valid_reg <= 1'b0;
         w_done_reg  <= 1'b0;
         i_rdata_reg <= '0;
         d_rdata_reg <= '0;
         m_addr_reg  <= '0;
         m_wdata_reg <= '0;
         m_be_reg    <= '0;
         m_we_reg    <= 1'b0;
         cnt_reg     <= 8'd0;
         bus_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            m_we_reg    <= (state_next == DWRITE);
            m_addr_reg  <= (state_next == IFETCH) ? i_addr : d_addr;
            m_wdata_reg <= (state_next == DWRITE) ? d_wdata : '0;
            m_be_reg    <= (state_next == IFETCH) ? {BE_W{1'b1}} : d_be;
         end
         // the acked transaction's flag wins over a same-cycle pipe_adv clear
         i_valid_reg <= (i_valid_reg && !pipe_adv) || set_i;
         d_valid_reg <= (d_valid_reg && !pipe_adv) || set_d;
         w_done_reg  <= (w_done_reg  && !pipe_adv) || set_w;
         if (set_i)
            i_rdata_reg <= m_rdata;
         if (set_d)
            d_rdata_reg <= m_rdata;
         cnt_reg <= cnt_next;
         if ((state_reg != IDLE) && !m_ack && (cnt_next == TIMEOUT_C))
            bus_err_reg <= 1'b1;
      end
   end

   assign i_rdata  = i_rdata_reg;
   assign d_rdata  = d_rdata_reg;
   assign iready_n = !i_valid_reg;
   assign dready_n = !d_valid_reg;
   assign dbusy    = d_rw[0] && !w_done_reg;
   assign m_req    = (state_reg != IDLE);
   assign m_we     = m_we_reg;
   assign m_addr   = m_addr_reg;
   assign m_wdata  = m_wdata_reg;
   assign m_be     = m_be_reg;
   assign bus_err  = bus_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts
// the handshakes and issued memory requests; a monitor checks them.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          iready_n;
   logic [1:0]    d_rw;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [BW-1:0] d_be;
   logic [DW-1:0] d_rdata;
   logic          dready_n;
   logic          dbusy;
   logic          pipe_adv;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [BW-1:0] m_be;
   logic          m_ack;
   logic [DW-1:0] m_rdata;
   logic          bus_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .iready_n(iready_n),
      .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .dready_n(dready_n), .dbusy(dbusy),
      .pipe_adv(pipe_adv),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata), .bus_err(bus_err)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } txn_t;

   txn_t exp_q[$];
   txn_t cur;

   int n_cmp = 0;
   int n_err = 0;
   int checking = 0;

   // transaction-level memory port model
   int            busy = 0;
   int            kind = 0;    // 0 fetch, 1 load, 2 store
   logic [AW-1:0] t_addr = '0;
   int            lat = 0;
   int            force_lat = -1;
   int            max_lat = 0;
   logic          mi_v = 1'b0, md_v = 1'b0, mw_d = 1'b0;
   logic [DW-1:0] mi_data = '0, md_data = '0;
   int            tcnt = 0;
   logic          merr = 1'b0;
   logic          prev_req = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic start_txn(input int k);
      txn_t t;
      busy   = 1;
      kind   = k;
      t_addr = (k == 0) ? i_addr : d_addr;
      tcnt   = 0;
      lat    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, max_lat));
      force_lat = -1;
      t.we    = (k == 2);
      t.addr  = t_addr;
      t.wdata = d_wdata;
      t.be    = d_be;
      exp_q.push_back(t);
   endtask

   // applies the rules for the cycle that just ended at this clock edge
   task automatic model_edge();
      logic si, sd, sw;
      si = 1'b0; sd = 1'b0; sw = 1'b0;
      if (!rst) begin
         busy = 0; mi_v = 0; md_v = 0; mw_d = 0;
         mi_data = '0; md_data = '0; tcnt = 0; merr = 0; lat = 0;
      end else begin
         if (busy == 0) begin
            if (d_rw[1] && !md_v)      start_txn(1);
            else if (d_rw[0] && !mw_d) start_txn(2);
            else if (i_req && !mi_v)   start_txn(0);
         end else if (m_ack) begin
            busy = 0;
            tcnt = 0;
            si = (kind == 0) && (t_addr == i_addr);
            sd = (kind == 1);
            sw = (kind == 2);
         end else begin
            if (tcnt < 255) tcnt++;
            if (tcnt == TO) merr = 1'b1;
         end
         if (pipe_adv) begin mi_v = 0; md_v = 0; mw_d = 0; end
         if (si) begin mi_v = 1; mi_data = m_rdata; end
         if (sd) begin md_v = 1; md_data = m_rdata; end
         if (sw) mw_d = 1;
      end
   endtask

   function automatic logic chance(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   task automatic run_phase(input int cycles, input int p_ireq, input int p_dr,
                            input int p_dw, input int p_adv, input int p_redir,
                            input int p_rst, input int mlat);
      max_lat = mlat;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         model_edge();
         #1;
         rst      = chance(p_rst) ? 1'b0 : 1'b1;
         i_req    = chance(p_ireq);
         if (chance(p_redir)) i_addr = 32'($urandom_range(1, 4)) << 8;
         d_rw     = {chance(p_dr), chance(p_dw)};
         d_addr   = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
         d_wdata  = $urandom;
         d_be     = 4'($urandom);
         pipe_adv = chance(p_adv);
         m_rdata  = $urandom;
         if (busy != 0) begin
            m_ack = (lat == 0);
            if (lat > 0) lat--;
         end else begin
            m_ack = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (checking != 0) begin
         check("iready_n", 64'(iready_n), 64'(!mi_v));
         check("dready_n", 64'(dready_n), 64'(!md_v));
         check("dbusy",    64'(dbusy),    64'(d_rw[0] && !mw_d));
         check("m_req",    64'(m_req),    64'(busy != 0));
         check("bus_err",  64'(bus_err),  64'(merr));
         check("i_rdata",  64'(i_rdata),  64'(mi_data));
         check("d_rdata",  64'(d_rdata),  64'(md_data));
         if (m_req && !prev_req) begin
            if (exp_q.size() == 0) begin
               check("txn_unexpected", 64'(1), 64'(0));
            end else begin
               cur = exp_q.pop_front();
               check("m_we", 64'(m_we), 64'(cur.we));
               if (cur.we) begin
                  check("m_wdata", 64'(m_wdata), 64'(cur.wdata));
                  check("m_be",    64'(m_be),    64'(cur.be));
               end
            end
         end
         if (m_req) begin
            check("m_addr", 64'(m_addr), 64'(cur.addr));
            if (cur.we) check("m_wdata_stable", 64'(m_wdata), 64'(cur.wdata));
         end
         $display("cyc t=%0t req=%0b we=%0b addr=%0h ack=%0b irdy_n=%0b drdy_n=%0b dbusy=%0b err=%0b",
                  $time, m_req, m_we, m_addr, m_ack, iready_n, dready_n, dbusy, bus_err);
         prev_req = m_req;
      end
   end

   initial begin
      cur = '{we: 1'b0, addr: '0, wdata: '0, be: '0};
      rst = 1'b0; i_req = 1'b0; i_addr = 32'h100; d_rw = 2'b01;
      d_addr = 32'h2000; d_wdata = '0; d_be = '0; pipe_adv = 1'b0;
      m_ack = 1'b0; m_rdata = '0;
      @(posedge clk);
      model_edge();
      #1;
      checking = 1;
      // fetch-only at zero latency from 0x100
      run_phase(40,  100, 0, 0, 20, 0, 0, 0);
      // mixed load/store/fetch contention
      run_phase(400, 70, 30, 30, 30, 10, 0, 3);
      // stores with longer acks
      run_phase(200, 0, 0, 80, 20, 0, 0, 4);
      // frequent branch redirects
      run_phase(300, 90, 10, 10, 25, 50, 0, 2);
      // one transaction left unacknowledged past the timeout
      force_lat = 300;
      run_phase(330, 100, 0, 0, 100, 0, 0, 0);
      run_phase(20,  50, 20, 20, 30, 10, 0, 2);
      // mixed traffic with resets landing mid-transaction
      run_phase(600, 60, 40, 30, 30, 10, 3, 3);
      @(negedge clk);
      #1;
      check("txn_queue_empty", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
